gf163_serial_mult: RTL

Bit-serial GF(2^163) multiplier that replaces the fixed-delay counter as the processing engine behind the LA-driven operand loader. In the loader's `proc` state it consumes two 163-bit operand registers and runs under the loader's `enb` level. It computes a·b mod f(x), f(x) = x^163 + x^7 + x^6 + x^3 + 1, and raises `done`, which the loader uses to enter `read_mode`. The result stays registered for readback over the LA.

---
 rtl/bec_pkg.sv | 24 ++
 rtl/gf163_serial_mult_if.sv | 16 +
 rtl/gf163_serial_mult_xtime.sv | 12 +
 rtl/gf163_serial_mult.sv | 104 ++++++++++
 4 files changed

// File: rtl/bec_pkg.sv
// Shared constants and state encoding for the GF(2^163) engine and its loader.
// GF163_DIGIT2_EN selects the 2-bit-per-cycle build and its iteration count.
package bec_pkg;

  localparam int BEC_M = 163;
  localparam logic [BEC_M-1:0] BEC_POLY_LOW = 163'hC9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } bec_state_t;

`ifdef GF163_DIGIT2_EN
  localparam int BEC_ITER = 82;
  localparam int BEC_B_W  = 164;
`else
  localparam int BEC_ITER = 163;
  localparam int BEC_B_W  = 163;
`endif

  localparam int BEC_CNT_W = $clog2(BEC_ITER);

endpackage

// File: rtl/gf163_serial_mult_if.sv
// Loader-side handshake and operand/result bus of the GF(2^163) multiplier.
interface gf163_serial_mult_if
  import bec_pkg::*;
#(
  parameter int M = BEC_M
);
  logic         enb;
  logic [M-1:0] op_a;
  logic [M-1:0] op_b;
  logic [M-1:0] result;
  logic         busy;
  logic         done;

  modport master (output enb, op_a, op_b, input result, busy, done);
  modport slave  (input enb, op_a, op_b, output result, busy, done);
endinterface

// File: rtl/gf163_serial_mult_xtime.sv
// Combinational multiply-by-x in GF(2^M), folding x^M back in through the low terms of f(x).
module gf163_xtime
  import bec_pkg::*;
#(
  parameter int M = BEC_M,
  parameter logic [M-1:0] POLY_LOW = BEC_POLY_LOW
) (
  input  logic [M-1:0] i_v,
  output logic [M-1:0] o_v
);
  assign o_v = {i_v[M-2:0], 1'b0} ^ (i_v[M-1] ? POLY_LOW : '0);
endmodule

// File: rtl/gf163_serial_mult.sv
// Bit-serial GF(2^163) multiplier, MSB-first, result registered for loader readback.
// Define GF163_DIGIT2_EN for the digit-serial build that retires 2 multiplier bits per cycle.
//
// state   | meaning
// IDLE    | waiting for enb; operands latched on the start edge
// RUN     | accumulating one digit of b per cycle
// DONE    | product valid in result, waiting for enb to drop
module gf163_serial_mult
  import bec_pkg::*;
#(
  parameter int M = BEC_M,
  parameter logic [M-1:0] POLY_LOW = BEC_POLY_LOW
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  gf163_serial_mult_if.slave bus
);

  bec_state_t           r_state;
  bec_state_t           w_state_next;
  logic [M-1:0]         r_a;
  logic [BEC_B_W-1:0]   r_b;
  logic [M-1:0]         r_acc;
  logic [M-1:0]         r_result;
  logic [BEC_CNT_W-1:0] r_cnt;
  logic [M-1:0]         w_acc_x;
  logic [M-1:0]         w_acc_next;
  logic                 w_last;

  assign w_last = (r_cnt == '0);

`ifdef GF163_DIGIT2_EN
  // Horner form: xtime(xtime(acc) ^ b1*a) ^ b0*a == acc*x^2 ^ b1*a*x ^ b0*a
  logic [BEC_CNT_W:0] w_idx_hi;
  logic [BEC_CNT_W:0] w_idx_lo;
  logic [M-1:0]       w_stage1;
  logic [M-1:0]       w_stage2;

  assign w_idx_hi = {r_cnt, 1'b1};
  assign w_idx_lo = {r_cnt, 1'b0};

  gf163_xtime #(.M(M), .POLY_LOW(POLY_LOW)) u_xtime_hi (.i_v(r_acc), .o_v(w_acc_x));
  assign w_stage1 = w_acc_x ^ (r_b[w_idx_hi] ? r_a : '0);

  gf163_xtime #(.M(M), .POLY_LOW(POLY_LOW)) u_xtime_lo (.i_v(w_stage1), .o_v(w_stage2));
  assign w_acc_next = w_stage2 ^ (r_b[w_idx_lo] ? r_a : '0);
`else
  gf163_xtime #(.M(M), .POLY_LOW(POLY_LOW)) u_xtime (.i_v(r_acc), .o_v(w_acc_x));
  assign w_acc_next = w_acc_x ^ (r_b[r_cnt] ? r_a : '0);
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.enb) w_state_next = ST_RUN;
      ST_RUN: begin
        if (!bus.enb)    w_state_next = ST_IDLE;
        else if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: if (!bus.enb) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.enb) begin
            r_a   <= bus.op_a;
            r_b   <= BEC_B_W'(bus.op_b);
            r_acc <= '0;
            r_cnt <= BEC_CNT_W'(BEC_ITER - 1);
          end
        end
        ST_RUN: begin
          // an abort leaves result untouched; only the final digit commits it
          if (bus.enb) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt - 1'b1;
            if (w_last) r_result <= w_acc_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (r_state == ST_RUN);
  assign bus.done   = (r_state == ST_DONE);
  assign bus.result = r_result;

endmodule
